inst_queue: RTL and testbench



---
 rtl/inst_queue_pkg.sv | 29 ++
 rtl/inst_queue_if.sv | 26 ++
 rtl/inst_queue_chk.sv | 27 ++
 rtl/inst_queue.sv | 98 +++++++++
 tb/tb_inst_queue.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch -> decode instruction queue: entry bundle, exception
// record and the default queue depth.
package inst_queue_pkg;

    localparam int INST_QUEUE_DEPTH = 16;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_TLBL = 5'd2;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;

    typedef struct packed {
        logic       ex;
        logic [4:0] exccode;
        logic       tlb_refill;
    } exception_t;

    typedef struct packed {
        virt_t      pc;
        uint32_t    inst;
        exception_t exception;
    } fetch_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push port and decode-side dual read port of the instruction queue.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic [1:0]         fetch_valid;
    virt_t [1:0]        fetch_pc;
    uint32_t [1:0]      fetch_inst;
    exception_t [1:0]   fetch_exception;
    logic               fetch_ready;
    logic [1:0]         decode_valid;
    virt_t [1:0]        decode_pc;
    uint32_t [1:0]      decode_inst;
    exception_t [1:0]   decode_exception;
    logic [1:0]         decode_accept;

    modport master (
        output fetch_valid, fetch_pc, fetch_inst, fetch_exception, decode_accept,
        input  fetch_ready, decode_valid, decode_pc, decode_inst, decode_exception
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_inst, fetch_exception, decode_accept,
        output fetch_ready, decode_valid, decode_pc, decode_inst, decode_exception
    );

endinterface

// File: rtl/inst_queue_chk.sv
// Occupancy and decode-handshake assertions for inst_queue.
module inst_queue_chk #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input logic             clk,
    input logic             reset,
    input logic [CNT_W-1:0] count_q,
    input logic [CNT_W-1:0] count_d,
    input logic [1:0]       decode_accept
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Sample invariants on every active edge outside reset
    always @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= DEPTH_C)
                else $error("inst_queue: occupancy %0d above depth", count_q);
            assert (count_d <= DEPTH_C)
                else $error("inst_queue: next occupancy %0d out of range", count_d);
            assert (decode_accept != 2'b10)
                else $warning("inst_queue: decode_accept 2'b10 ignored");
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Dual-issue circular instruction buffer between fetch and the two decode slots.
// Up to two pushes and two pops per cycle; flush empties it.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic         clk,
    input logic         reset,
    input logic         flush,
    inst_queue_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    fetch_entry_t     storage_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             fetch_ready_s, push_ok_s, wr_en0_s, wr_en1_s;
    logic [1:0]       decode_valid_s, accept_s, push_n_s, pop_n_s;
    logic [PTR_W-1:0] head_p1_s, tail_p1_s;
    fetch_entry_t     slot0_s, slot1_s, wr_data0_s, wr_data1_s, out0_s, out1_s;

    // Push compaction, pop count and next-state pointers
    always_comb begin
        slot0_s        = {q.fetch_pc[0], q.fetch_inst[0], q.fetch_exception[0]};
        slot1_s        = {q.fetch_pc[1], q.fetch_inst[1], q.fetch_exception[1]};
        fetch_ready_s  = (count_q <= READY_MAX);
        decode_valid_s = {count_q >= CNT_W'(2), count_q >= CNT_W'(1)};
        push_ok_s      = fetch_ready_s && !flush && !reset;
        push_n_s       = push_ok_s ? popcount2(q.fetch_valid) : 2'd0;
        // An out-of-order pop mask cannot be honoured, so it pops nothing
        accept_s       = (q.decode_accept == 2'b10) ? 2'b00 : q.decode_accept;
        pop_n_s        = popcount2(accept_s & decode_valid_s);
        wr_en0_s       = push_ok_s && (q.fetch_valid != 2'b00);
        wr_en1_s       = push_ok_s && (q.fetch_valid == 2'b11);
        wr_data0_s     = q.fetch_valid[0] ? slot0_s : slot1_s;
        wr_data1_s     = slot1_s;
        head_p1_s      = head_q + PTR_W'(1);
        tail_p1_s      = tail_q + PTR_W'(1);
        head_d         = head_q + PTR_W'(pop_n_s);
        tail_d         = tail_q + PTR_W'(push_n_s);
        count_d        = count_q + CNT_W'(push_n_s) - CNT_W'(pop_n_s);
    end

    // Pointer and occupancy registers; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, two write ports, contents intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en0_s) begin
            storage_q[tail_q] <= wr_data0_s;
        end
        if (wr_en1_s) begin
            storage_q[tail_p1_s] <= wr_data1_s;
        end
    end

    // Read head and head+1, zeroing slots that hold no valid entry
    always_comb begin
        out0_s = decode_valid_s[0] ? storage_q[head_q]    : '0;
        out1_s = decode_valid_s[1] ? storage_q[head_p1_s] : '0;
    end

    assign q.fetch_ready         = fetch_ready_s;
    assign q.decode_valid        = decode_valid_s;
    assign q.decode_pc[0]        = out0_s.pc;
    assign q.decode_pc[1]        = out1_s.pc;
    assign q.decode_inst[0]      = out0_s.inst;
    assign q.decode_inst[1]      = out1_s.inst;
    assign q.decode_exception[0] = out0_s.exception;
    assign q.decode_exception[1] = out1_s.exception;

    inst_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .count_q       (count_q),
        .count_d       (count_d),
        .decode_accept (q.decode_accept)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue of expected entries is fed on push
// and consumed on accepted pops; decode outputs are compared against its front.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = INST_QUEUE_DEPTH;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    inst_queue_if q_if ();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .q     (q_if)
    );

    fetch_entry_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] pc_ctr = 32'h8000_1000;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic fetch_entry_t ent(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc        = pc;
        e.inst      = pc ^ 32'h5A5A_1234;
        e.exception = '0;
        return e;
    endfunction

    function automatic fetch_entry_t next_ent();
        pc_ctr = pc_ctr + 32'd4;
        return ent(pc_ctr);
    endfunction

    // One clock: drive, compare outputs against the model, then advance the model
    task automatic cycle(input logic [1:0] fv, input fetch_entry_t s0, input fetch_entry_t s1,
                         input logic [1:0] acc, input logic fl);
        fetch_entry_t e0, e1;
        logic rdy;
        int n;
        @(negedge clk);
        q_if.fetch_valid        = fv;
        q_if.fetch_pc[0]        = s0.pc;
        q_if.fetch_inst[0]      = s0.inst;
        q_if.fetch_exception[0] = s0.exception;
        q_if.fetch_pc[1]        = s1.pc;
        q_if.fetch_inst[1]      = s1.inst;
        q_if.fetch_exception[1] = s1.exception;
        q_if.decode_accept      = acc;
        flush                   = fl;
        #1;
        rdy = ((DEPTH - sb.size()) >= 2);
        e0  = (sb.size() >= 1) ? sb[0] : '0;
        e1  = (sb.size() >= 2) ? sb[1] : '0;
        check_eq("fetch_ready", {127'd0, q_if.fetch_ready}, {127'd0, rdy});
        check_eq("decode_valid", {126'd0, q_if.decode_valid},
                 {126'd0, (sb.size() >= 2), (sb.size() >= 1)});
        check_eq("decode_slot0", {57'd0, q_if.decode_pc[0], q_if.decode_inst[0],
                 q_if.decode_exception[0]}, {57'd0, e0});
        check_eq("decode_slot1", {57'd0, q_if.decode_pc[1], q_if.decode_inst[1],
                 q_if.decode_exception[1]}, {57'd0, e1});
        if (fl) begin
            sb.delete();
        end else begin
            n = 0;
            if (acc != 2'b10) begin
                if (acc[0] && sb.size() >= 1) n++;
                if (acc[1] && sb.size() >= 2) n++;
            end
            for (int i = 0; i < n; i++) void'(sb.pop_front());
            if (rdy) begin
                if (fv[0]) sb.push_back(s0);
                if (fv[1]) sb.push_back(s1);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        q_if.fetch_valid   = 2'b11;
        q_if.decode_accept = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q_if.fetch_valid   = 2'b00;
        q_if.decode_accept = 2'b00;
        sb.delete();
    endtask

    initial begin : stim
        fetch_entry_t a, b;
        logic [1:0] acc;
        reset = 1'b1;
        flush = 1'b0;
        q_if.fetch_valid     = 2'b00;
        q_if.fetch_pc        = '0;
        q_if.fetch_inst      = '0;
        q_if.fetch_exception = '0;
        q_if.decode_accept   = 2'b00;
        do_reset();

        // Reset state, then first dual push with an AdEL on slot 0
        cycle(2'b00, '0, '0, 2'b00, 1'b0);
        a = ent(32'hBFC0_0000);
        a.exception = '{ex: 1'b1, exccode: EXC_ADEL, tlb_refill: 1'b0};
        b = ent(32'hBFC0_0004);
        cycle(2'b11, a, b, 2'b00, 1'b0);
        cycle(2'b00, '0, '0, 2'b10, 1'b0);
        cycle(2'b00, '0, '0, 2'b00, 1'b0);
        cycle(2'b00, '0, '0, 2'b11, 1'b0);

        // Fill to capacity, with extra pushes that must be dropped
        for (int i = 0; i < 10; i++) begin
            a = next_ent();
            b = next_ent();
            cycle(2'b11, a, b, 2'b00, 1'b0);
        end
        for (int i = 0; i < 9; i++) cycle(2'b00, '0, '0, 2'b11, 1'b0);

        // Slot1-only push into an empty queue
        cycle(2'b10, '0, ent(32'h8000_0004), 2'b00, 1'b0);
        cycle(2'b00, '0, '0, 2'b01, 1'b0);

        // Odd head offset then steady dual push/pop crossing the wrap point
        cycle(2'b01, next_ent(), '0, 2'b00, 1'b0);
        for (int i = 0; i < 24; i++) begin
            a = next_ent();
            b = next_ent();
            cycle(2'b11, a, b, 2'b11, 1'b0);
        end

        // Flush with concurrent push and pop on a partly filled queue
        cycle(2'b00, '0, '0, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = next_ent();
            b = next_ent();
            cycle((i == 2) ? 2'b01 : 2'b11, a, b, 2'b00, 1'b0);
        end
        a = next_ent();
        b = next_ent();
        cycle(2'b11, a, b, 2'b11, 1'b1);
        cycle(2'b00, '0, '0, 2'b00, 1'b0);

        // Random traffic with occasional flush and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            a = next_ent();
            b = next_ent();
            a.exception = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 2))
                0:       acc = 2'b00;
                1:       acc = 2'b01;
                default: acc = 2'b11;
            endcase
            if (i == 200) do_reset();
            cycle(2'($urandom_range(0, 3)), a, b, acc, ($urandom_range(0, 24) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
